// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, issues one imem request at a time, hands instr/pcOut to decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in a sticky FAULT state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        fetchFault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDrop, StFault} state_e;
`else
    typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDrop} state_e;
`endif

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_instr, r_pc_out, r_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_capture;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault, w_fault_d;
    // Misaligned redirect seen while a response is still in flight.
    logic r_pend, w_pend_d;
    logic w_misaligned;

    assign w_misaligned  = (branchTarget[1:0] != 2'b00);
    assign w_redirect_pc = branchTarget;
    assign fetchFault    = r_fault;
`else
    assign w_redirect_pc = branchTarget & ~32'h3;
    assign fetchFault    = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_capture = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        w_fault_d = r_fault;
        w_pend_d  = r_pend;
`endif
        unique case (r_state)
            StIdle: w_state_d = StReq;
            StReq:  if (imem_gnt) w_state_d = StWait;
            StWait: begin
                if (imem_rvalid) begin
                    w_state_d = StOut;
                    w_capture = 1'b1;
                end
            end
            StOut: begin
                if (!stall) begin
                    w_state_d = StReq;
                    w_pc_d    = r_pc + 32'd4;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    w_state_d = r_pend ? StFault : StReq;
                    w_pend_d  = 1'b0;
`else
                    w_state_d = StReq;
`endif
                end
            end
            default: w_state_d = r_state;
        endcase

        // Redirect overrides stall and sequential advance; a grant in the same
        // cycle belongs to the old address, so its response must be drained.
        if (branchTaken) begin
            w_pc_d    = w_redirect_pc;
            w_capture = 1'b0;
            unique case (r_state)
                StReq:   w_state_d = imem_gnt ? StDrop : StReq;
                StWait:  w_state_d = imem_rvalid ? StReq : StDrop;
                StDrop:  w_state_d = imem_rvalid ? StReq : StDrop;
                default: w_state_d = StReq;
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            w_fault_d = w_misaligned;
            w_pend_d  = 1'b0;
            if (w_misaligned) begin
                if (w_state_d == StReq) w_state_d = StFault;
                else                    w_pend_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_pc_out   <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault    <= 1'b0;
            r_pend     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_pc_out   <= r_pc;
                r_pc_plus4 <= r_pc + 32'd4;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= w_fault_d;
            r_pend  <= w_pend_d;
`endif
        end
    end

    assign imem_req    = (r_state == StReq);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == StOut);
    assign instr       = r_instr;
    assign pcOut       = r_pc_out;
    assign pcPlus4     = r_pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected grants/instructions, monitor checks.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, branchTaken, stall, imem_gnt, imem_rvalid;
    logic [31:0] branchTarget, imem_rdata;
    logic        imem_req, instr_valid, fetchFault;
    logic [31:0] imem_addr, instr, pcOut, pcPlus4;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q_req[$];
    logic [95:0] q_out[$];
    logic        prev_valid = 1'b0;
    logic [95:0] e;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pcOut       (pcOut),
        .pcPlus4     (pcPlus4),
        .fetchFault  (fetchFault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (imem_req !== 1'b1) chk("req_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    // Zero-wait transaction; optional stall of `hold` cycles once in OUT.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int hold);
        wait_req();
        q_req.push_back(a);
        q_out.push_back({d, a, a + 32'd4});
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        stall       = (hold > 0);
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, d);
            chk("hold_pc", pcOut, a);
            chk("hold_noreq", {31'b0, imem_req}, 32'd0);
            cyc();
        end
        if (hold > 0) begin
            stall = 1'b0;
            cyc();
            chk("release_req", {31'b0, imem_req}, 32'd1);
            chk("release_addr", imem_addr, a + 32'd4);
        end
    endtask

    always @(negedge clk) begin
        if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
            if (q_req.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_grant: got addr %h, expected none", imem_addr);
            end else begin
                chk("req_addr", imem_addr, q_req.pop_front());
            end
        end
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (q_out.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_instr: got %h at %h, expected none", instr, pcOut);
            end else begin
                e = q_out.pop_front();
                chk("instr", instr, e[95:64]);
                chk("pcOut", pcOut, e[63:32]);
                chk("pcPlus4", pcPlus4, e[31:0]);
            end
        end
        prev_valid <= (instr_valid === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        stall        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pcOut", pcOut, 32'h100);
        chk("rst_pcPlus4", pcPlus4, 32'h104);
        chk("rst_fault", {31'b0, fetchFault}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        cyc();
        rst_n = 1'b1;

        // First fetch, held in OUT by stall for 4 cycles.
        fetch(32'h100, 32'h2002_0005, 4);

        // Redirect while WAIT: response dropped.
        wait_req();
        q_req.push_back(32'h104);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt     = 1'b0;
        branchTaken  = 1'b1;
        branchTarget = 32'h400;
        cyc();
        branchTaken = 1'b0;
        chk("drop_noreq", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        chk("after_drop_req", {31'b0, imem_req}, 32'd1);
        chk("after_drop_addr", imem_addr, 32'h400);
        fetch(32'h400, 32'h1111_0001, 0);

        // Grant and redirect in the same cycle: grant is for the old address.
        wait_req();
        q_req.push_back(32'h404);
        imem_gnt     = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h500;
        cyc();
        imem_gnt    = 1'b0;
        branchTaken = 1'b0;
        chk("gnt_redir_noreq", {31'b0, imem_req}, 32'd0);
        cyc();
        chk("gnt_redir_noreq2", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0BAD;
        cyc();
        imem_rvalid = 1'b0;
        fetch(32'h500, 32'h2222_0002, 0);

        // Redirect in OUT while stalled.
        wait_req();
        q_req.push_back(32'h504);
        q_out.push_back({32'h3333_0003, 32'h504, 32'h508});
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_0003;
        stall       = 1'b1;
        cyc();
        imem_rvalid  = 1'b0;
        branchTaken  = 1'b1;
        branchTarget = 32'h200;
        @(negedge clk);
        chk("out_valid", {31'b0, instr_valid}, 32'd1);
        cyc();
        branchTaken = 1'b0;
        stall       = 1'b0;
        chk("redir_out_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_out_req", {31'b0, imem_req}, 32'd1);
        chk("redir_out_addr", imem_addr, 32'h200);
        fetch(32'h200, 32'h4444_0004, 0);

        // Redirect in REQ without grant, then PC wrap.
        wait_req();
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        cyc();
        branchTaken = 1'b0;
        chk("redir_req_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h5555_0005, 0);
        fetch(32'h0000_0000, 32'h6666_0006, 0);

        // Misaligned redirect.
        wait_req();
        branchTaken  = 1'b1;
        branchTarget = 32'h302;
        cyc();
        branchTaken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fault_set", {31'b0, fetchFault}, 32'd1);
            chk("fault_noreq", {31'b0, imem_req}, 32'd0);
            chk("fault_novalid", {31'b0, instr_valid}, 32'd0);
            cyc();
        end
        branchTaken  = 1'b1;
        branchTarget = 32'h300;
        cyc();
        branchTaken = 1'b0;
        chk("fault_clear", {31'b0, fetchFault}, 32'd0);
        chk("fault_exit_req", {31'b0, imem_req}, 32'd1);
`else
        chk("mask_nofault", {31'b0, fetchFault}, 32'd0);
        chk("mask_addr", imem_addr, 32'h300);
`endif
        fetch(32'h300, 32'h7777_0007, 0);

        // Reset mid-transaction; a late rvalid must be ignored.
        wait_req();
        q_req.push_back(32'h304);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        cyc();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00BA_DBAD;
        cyc();
        imem_rvalid = 1'b0;
        chk("late_rvalid_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_rvalid_instr", instr, 32'h0);
        chk("late_rvalid_req", {31'b0, imem_req}, 32'd1);
        chk("late_rvalid_addr", imem_addr, 32'h100);
        fetch(32'h100, 32'h8888_0008, 0);

        repeat (3) cyc();
        chk("req_queue_empty", q_req.size(), 32'd0);
        chk("out_queue_empty", q_out.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-address path: registers the PC and drives instruction-memory fetch requests from it.
- Accepts either sequential advance (PC+4) or a branch/jump redirect.
- Issues one outstanding request at a time over a req/gnt/rvalid handshake.
- Presents the fetched instruction with its PC to decode under a valid/stall handshake. Sits between the PC-select mux and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset and first address fetched after reset release

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
branchTaken  input  1  redirect strobe, sampled every cycle
branchTarget  input  32  redirect address, valid when branchTaken=1
stall  input  1  decode cannot accept instruction this cycle
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, equals current PC
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/pcOut hold a fetched instruction
instr  output  32  fetched instruction
pcOut  output  32  address of instr
pcPlus4  output  32  pcOut + 4, mod 2^32
fetchFault  output  1  misaligned redirect (feature only, else constant 0)

Behaviour:
- Reset (rst_n=0 at clock edge): PC=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, pcOut=RESET_PC, pcPlus4=RESET_PC+4, fetchFault=0. Reset mid-transaction abandons it; a late imem_rvalid arriving in IDLE or REQ is ignored.
- States: IDLE, REQ, WAIT, OUT, DROP (+FAULT with feature).
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=PC.
  - imem_gnt=1 -> WAIT.
  - While gnt=0, imem_addr stays stable unless a redirect occurs.
- WAIT: imem_req=0.
  - imem_rvalid=1 -> capture instr=imem_rdata, pcOut=PC, pcPlus4=PC+4, set instr_valid=1, -> OUT.
  - rvalid in the same cycle as gnt is not permitted by memory; ignored.
- OUT: instr_valid=1.
  - stall=0 -> PC<=PC+4, instr_valid<=0, -> REQ.
  - stall=1 -> hold all outputs, stay OUT.
- Minimum cost: 3 cycles per instruction (REQ, WAIT, OUT) with zero-wait memory.
- Redirect (branchTaken=1): has priority over stall and over sequential advance. PC<=branchTarget with bits [1:0] forced to 0.
  - IDLE/REQ -> REQ next cycle with the new address. A grant in the same cycle as the redirect is treated as granting the old address -> DROP.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid -> discard data, -> REQ.
  - OUT -> instr_valid<=0, -> REQ.
  - DROP -> update PC, stay DROP.
- DROP: wait for imem_rvalid, discard data, -> REQ; instr_valid stays 0.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag.
- Exactly one request is outstanding at any time; imem_req is never asserted in WAIT, DROP or OUT.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN
- Defined: a redirect with branchTarget[1:0]!=0 loads the PC unmasked and sets fetchFault=1 sticky. The state becomes FAULT directly from IDLE/REQ/OUT, or after the in-flight response drains via DROP. In FAULT: imem_req=0, instr_valid=0. An aligned redirect in FAULT clears fetchFault and goes to REQ. Reset also clears it.
- Not defined: low bits are masked and fetchFault is tied 0; there is no FAULT state.

Test Plan:
- Reset with RESET_PC=0x100, then release; gnt immediate, rvalid next cycle with 0x2002_0005 -> imem_addr=0x100; instr=0x2002_0005 valid with pcOut=0x100; next request at 0x104.
- Hold stall=1 for 4 cycles while in OUT -> instr/pcOut stable, no imem_req; on release, request at 0x104 one cycle later.
- branchTaken with target 0x400 while in WAIT, then rvalid with 0xDEAD_BEEF -> data dropped, instr_valid never 1 for it; next imem_addr=0x400.
- Redirect to 0x200 in OUT with stall=1 -> instr_valid falls next cycle, request at 0x200.
- PC=0xFFFF_FFFC fetched and consumed -> next imem_addr=0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x302 -> fetchFault=1, no requests; then redirect to 0x300 -> fault clears, request at 0x300. Without the macro, the same 0x302 redirect -> request at 0x300.
